// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared AES decryption widths, sequencer states and byte indexing
package aes_dec_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_NUM_BYTES = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;
  function automatic int byte_msb(input int i);
    return AES_STATE_W - 1 - 8 * i;
  endfunction
endpackage

// File: rtl/sbox.sv
// sbox: combinational AES inverse S-box lookup
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  assign out_byte = INV_SBOX[2047 - 8 * int'(in_byte) -: 8];
endmodule

// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq: InvSubBytes over a 128-bit state, NUM_SBOX bytes per cycle
module inv_subbytes_seq
  import aes_dec_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  input  logic         flush,
  output logic         busy
);
  localparam int CYCLES = AES_NUM_BYTES / NUM_SBOX;
  localparam int CW = CYCLES > 1 ? $clog2(CYCLES) : 1;
  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 && NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
    $error("inv_subbytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end
  seq_state_e st, nxt;
  logic [CW-1:0] cnt;
  logic [AES_STATE_W-1:0] work, work_nxt;
  logic [7:0] s_in [NUM_SBOX];
  logic [7:0] s_out [NUM_SBOX];
  logic accept, last, run, in_ready_d, out_valid_d, busy_d;
  assign accept = in_valid && in_ready && !flush;
  assign last = cnt == CW'(CYCLES - 1);
  assign run = st == RUN && !flush;
  assign out_state = work;
  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
    assign s_in[i] = work[byte_msb(int'(cnt) * NUM_SBOX + i) -: 8];
    sbox u_sbox (.in_byte(s_in[i]), .out_byte(s_out[i]));
  end
  // write this cycle's slice of lookups back into the working state in place
  always_comb begin
    work_nxt = work;
    for (int j = 0; j < NUM_SBOX; j++) work_nxt[byte_msb(int'(cnt) * NUM_SBOX + j) -: 8] = s_out[j];
  end
  // next state; flush wins over every handshake
  always_comb begin
    nxt = flush ? IDLE :
          st == IDLE ? (accept ? RUN : IDLE) :
          st == RUN ? (last ? DONE : RUN) :
          (out_ready ? IDLE : DONE);
  end
  // handshake outputs are registered, decoded from the state being entered
  always_comb begin
    in_ready_d = nxt == IDLE;
    out_valid_d = nxt == DONE;
    busy_d = nxt != IDLE;
  end
  // state, counter, working register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      work <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= run && !last ? cnt + 1'b1 : '0;
      work <= accept ? in_state : run ? work_nxt : work;
      in_ready <= in_ready_d;
      out_valid <= out_valid_d;
      busy <= busy_d;
    end
  end
endmodule

// File: tb/tb_inv_subbytes_seq.sv
// tb_inv_subbytes_seq: directed self-checking bench for inv_subbytes_seq
module tb_inv_subbytes_seq;
  localparam logic [127:0] KV_IN = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] KV_OUT = 128'h000102030405060708090a0b0c0d0e0f;
  logic clk = 1'b0;
  logic rst, in_valid, in_valid_x, in_ready, out_valid, out_ready, flush, busy, seen;
  logic [127:0] in_state, out_state;
  logic xo_valid [4];
  logic xi_ready [4];
  logic x_busy [4];
  logic [127:0] xo_state [4];
  int checks = 0;
  int failures = 0;
  int lat;
  int xlat [4];
  int xexp [4];
  always #5 clk = ~clk;
  inv_subbytes_seq #(.NUM_SBOX(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .flush(flush), .busy(busy)
  );
  for (genvar g = 0; g < 4; g++) begin : gx
    inv_subbytes_seq #(.NUM_SBOX(1 << (g == 0 ? 0 : g == 1 ? 1 : g == 2 ? 3 : 4))) u (
      .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(xi_ready[g]), .in_state(in_state),
      .out_valid(xo_valid[g]), .out_ready(out_ready), .out_state(xo_state[g]), .flush(flush), .busy(x_busy[g])
    );
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic chkn(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic chkw(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic accept_in(input logic [127:0] d);
    in_state = d;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step;
      n++;
    end
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_valid_x = 1'b0;
    out_ready = 1'b1;
    flush = 1'b0;
    in_state = '0;
    step;
    step;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step;
    chk1("rel_in_ready", in_ready, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("idle_rst_in_ready", in_ready, 1'b0);
    chk1("idle_rst_out_valid", out_valid, 1'b0);
    chk1("idle_rst_busy", busy, 1'b0);
    chkw("idle_rst_out_state", out_state, '0);
    rst = 1'b0;
    step;
    chk1("idle_rel_in_ready", in_ready, 1'b1);
    accept_in('0);
    chk1("zero_busy", busy, 1'b1);
    chk1("zero_in_ready", in_ready, 1'b0);
    wait_out(lat);
    chkn("zero_lat", lat, 4);
    chkw("zero_out", out_state, {16{8'h52}});
    step;
    chk1("zero_back_idle", in_ready, 1'b1);
    accept_in(KV_IN);
    wait_out(lat);
    chkn("kv_lat", lat, 4);
    chkw("kv_out", out_state, KV_OUT);
    step;
    xexp = '{16, 8, 2, 1};
    xlat = '{0, 0, 0, 0};
    out_ready = 1'b0;
    in_state = KV_IN;
    in_valid_x = 1'b1;
    step;
    in_valid_x = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step;
      for (int g = 0; g < 4; g++) if (xo_valid[g] && xlat[g] == 0) xlat[g] = c;
    end
    for (int g = 0; g < 4; g++) begin
      chkn($sformatf("x%0d_lat", g), xlat[g], xexp[g]);
      chkw($sformatf("x%0d_out", g), xo_state[g], KV_OUT);
    end
    out_ready = 1'b1;
    step;
    for (int g = 0; g < 4; g++) begin
      chk1($sformatf("x%0d_idle_ready", g), xi_ready[g], 1'b1);
      chk1($sformatf("x%0d_idle_busy", g), x_busy[g], 1'b0);
    end
    out_ready = 1'b0;
    accept_in(KV_IN);
    wait_out(lat);
    chkn("bp_lat", lat, 4);
    in_valid = 1'b1;
    in_state = '0;
    for (int c = 0; c < 10; c++) begin
      step;
      chk1("bp_out_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
      chkw("bp_out_state", out_state, KV_OUT);
    end
    out_ready = 1'b1;
    step;
    chk1("bp_rel_out_valid", out_valid, 1'b0);
    chk1("bp_rel_in_ready", in_ready, 1'b1);
    chk1("bp_rel_busy", busy, 1'b0);
    step;
    in_valid = 1'b0;
    chk1("bp_next_busy", busy, 1'b1);
    wait_out(lat);
    chkn("bp_next_lat", lat, 4);
    chkw("bp_next_out", out_state, {16{8'h52}});
    step;
    accept_in({16{8'hff}});
    step;
    step;
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk1("fl_busy", busy, 1'b0);
    chk1("fl_in_ready", in_ready, 1'b1);
    chk1("fl_out_valid", out_valid, 1'b0);
    seen = 1'b0;
    repeat (6) begin
      step;
      seen |= out_valid;
    end
    chk1("fl_no_out_valid", seen, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_state = {16{8'hff}};
    step;
    flush = 1'b0;
    in_valid = 1'b0;
    chk1("fl_idle_no_accept", busy, 1'b0);
    chk1("fl_idle_in_ready", in_ready, 1'b1);
    accept_in({16{8'hff}});
    wait_out(lat);
    chkn("fl_next_lat", lat, 4);
    chkw("fl_next_out", out_state, {16{8'h7d}});
    step;
    accept_in(KV_IN);
    step;
    #2 rst = 1'b1;
    #1;
    chk1("run_rst_in_ready", in_ready, 1'b0);
    chk1("run_rst_out_valid", out_valid, 1'b0);
    chk1("run_rst_busy", busy, 1'b0);
    chkw("run_rst_out_state", out_state, '0);
    rst = 1'b0;
    step;
    chk1("run_rel_in_ready", in_ready, 1'b1);
    accept_in({16{8'h52}});
    wait_out(lat);
    chkn("run_next_lat", lat, 4);
    chkw("run_next_out", out_state, {16{8'h48}});
    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
